dup_lane_leak_checker: RTL and testbench
========================================

Name: dup_lane_leak_checker

Overview:
- Parametrised N-lane self-composition harness: LANES copies of the secret-dependent a/b/c/out datapath.
- All lanes share public inputs x, y, z; each lane has its own secret h.
- An on-chip checker compares every lane against lane 0 and flags any divergence as an information leak.
- Used as the synthesisable, simulatable counterpart of the two-copy noninterference proofs, with selectable compare mode, sticky flags and first-leak capture.

Parameters:
- W, 32, datapath width of x/y/z/h and of all lane registers.
- LANES, 2, number of composed copies (>=2); lane 0 is the comparison baseline.
- DEPTH, 1, output delay-line stages after the out register (>=1).
- CNT_W, 16, width of the free-running cycle counter and of first_cycle.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- valid_in  in  1  advances all lane datapaths this cycle.
- x  in  W  public operand.
- y  in  W  public operand.
- z  in  W  public operand.
- h  in  LANES*W  per-lane secret, lane i at bits [i*W +: W].
- mode  in  1  0 = compare delayed outputs only; 1 = compare full internal state.
- clear  in  1  clears sticky leak state.
- dout  out  LANES*W  per-lane delayed out value.
- dout_valid  out  1  dout carries an out produced by an accepted valid_in.
- leak  out  LANES  sticky per-lane mismatch flag; bit 0 is tied 0.
- leak_any  out  1  OR of leak.
- first_cycle  out  CNT_W  cycle-counter value when the first leak was detected.
- first_lane  out  max(1,$clog2(LANES))  lowest lane index flagged at first detection.

Behaviour:
- Reset (async, reset_n=0):
  - all a/b/c/o registers, delay line, valid shift, leak, first_cycle, first_lane and cycle counter go to 0;
  - dout=0, dout_valid=0, leak_any=0.
- Lane update, on a clk edge with valid_in=1, per lane i, using pre-edge register values:
  - b <= x-y.
  - If h_i != 0: c <= x+y and a <= b-c.
  - Else: a <= b+z and c holds.
  - o <= a+b+c.
  - All arithmetic is mod 2^W, unsigned.
- valid_in=0: a/b/c/o hold.
- Delay line and valid path:
  - The delay line shifts every cycle unconditionally.
  - dout = o delayed DEPTH cycles.
  - dout_valid = valid_in delayed DEPTH+1 cycles.
- Cycle counter: increments every cycle from 0 and saturates at all-ones.
- Comparison, combinational each cycle, for lanes i=1..LANES-1:
  - mode=0: mismatch_i = dout_valid & (dout_i != dout_0).
  - mode=1: mismatch_i = (a_i,b_i,c_i,o_i) != (a_0,b_0,c_0,o_0), evaluated every cycle.
  - Mode may change at any cycle and takes effect immediately.
- Sticky flags:
  - leak[i] <= leak[i] | mismatch_i, registered, so it sets one cycle after the divergence is visible.
  - Only reset or clear lowers a flag.
- First-leak capture:
  - Triggers on the edge where leak_any transitions 0->1.
  - first_cycle <= counter value, first_lane <= lowest i with mismatch_i.
  - Later leaks do not update either field.
- clear=1 at an edge: leak, first_cycle and first_lane go to 0.
  - If a mismatch is present in the same cycle, mismatch wins: the flag is set and capture occurs with the current counter value.
- Reset mid-run: all state returns to reset values regardless of in-flight delay-line contents; dout_valid drops immediately.

Optional Feature:
- Macro LEAK_COUNT_EN.
- When defined:
  - adds output leak_count (LANES*CNT_W);
  - per-lane saturating count of cycles with mismatch_i=1;
  - cleared by reset and clear; lane 0 count is tied 0;
  - clear with simultaneous mismatch loads 1.
- When undefined: the port and counters are absent, and all other behaviour is identical.

Test Plan:
- W=8, LANES=2, DEPTH=2, mode=0, h0=h1=0, 10 valid_in cycles with random x/y/z -> leak=0, leak_any=0 throughout; dout lanes equal.
- mode=1, h0=1, h1=0, x=5, y=3, z=0, one valid_in at cycle 2:
  - post-edge b=2 both lanes, c0=8, c1=0;
  - leak[1]=1 at cycle 4; first_cycle=3; first_lane=1.
- mode=0, same stimulus with two consecutive valid_in:
  - o0=10, o1=2 after the 2nd edge;
  - dout differs once dout_valid=1;
  - leak[1] sets one cycle later; earlier cycles show no leak.
- LANES=4, h=(0,0,7,7), mode=1:
  - leak=4'b1100 after the first valid_in plus one cycle;
  - first_lane=2.
- clear pulsed in the same cycle as an ongoing mismatch -> leak stays 1; first_cycle reloads the current counter; with LEAK_COUNT_EN, leak_count lane reads 1.
- reset_n asserted mid-stream with dout_valid=1 -> all outputs 0 immediately; after release, the first dout_valid appears DEPTH+1 cycles after the next valid_in.

Source files
------------

// File: rtl/dup_lane_leak_checker.sv
// rtl/dup_lane_leak_checker.sv - N-lane self-composed datapath with on-chip divergence (leak) checker.
// Optional macro LEAK_COUNT_EN adds per-lane saturating mismatch-cycle counters on leak_count.
module dup_lane_leak_checker #(
    parameter int W     = 32,
    parameter int LANES = 2,
    parameter int DEPTH = 1,
    parameter int CNT_W = 16
) (
    input  logic                                       clk,
    input  logic                                       reset_n,
    input  logic                                       valid_in,
    input  logic [W-1:0]                               x,
    input  logic [W-1:0]                               y,
    input  logic [W-1:0]                               z,
    input  logic [LANES*W-1:0]                         h,
    input  logic                                       mode,
    input  logic                                       clear,
    output logic [LANES*W-1:0]                         dout,
    output logic                                       dout_valid,
    output logic [LANES-1:0]                           leak,
    output logic                                       leak_any,
    output logic [CNT_W-1:0]                           first_cycle,
    output logic [((LANES > 1) ? $clog2(LANES) : 1)-1:0] first_lane
`ifdef LEAK_COUNT_EN
    ,
    output logic [LANES*CNT_W-1:0]                     leak_count
`endif
);
    localparam int FL_W = (LANES > 1) ? $clog2(LANES) : 1;

    logic [W-1:0]     ra    [LANES];
    logic [W-1:0]     rb    [LANES];
    logic [W-1:0]     rc    [LANES];
    logic [W-1:0]     ro    [LANES];
    logic [W-1:0]     dline [LANES][DEPTH];
    logic [DEPTH:0]   vshift;
    logic [CNT_W-1:0] cnt;
    logic [LANES-1:0] mism;
    logic [FL_W-1:0]  low_lane;

    // Lane datapaths: every right-hand side reads the pre-edge register values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LANES; i++) begin
                ra[i] <= '0;
                rb[i] <= '0;
                rc[i] <= '0;
                ro[i] <= '0;
            end
        end else if (valid_in) begin
            for (int i = 0; i < LANES; i++) begin
                rb[i] <= x - y;
                if (h[i*W +: W] != '0) begin
                    rc[i] <= x + y;
                    ra[i] <= rb[i] - rc[i];
                end else begin
                    ra[i] <= rb[i] + z;
                end
                ro[i] <= ra[i] + rb[i] + rc[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LANES; i++) begin
                for (int j = 0; j < DEPTH; j++) begin
                    dline[i][j] <= '0;
                end
            end
            vshift <= '0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                dline[i][0] <= ro[i];
                for (int j = 1; j < DEPTH; j++) begin
                    dline[i][j] <= dline[i][j-1];
                end
            end
            vshift <= {vshift[DEPTH-1:0], valid_in};
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_dout
        assign dout[g*W +: W] = dline[g][DEPTH-1];
    end
    assign dout_valid = vshift[DEPTH];
    assign leak_any   = |leak;

    // Descending scan so the lowest mismatching lane is the last one written.
    always_comb begin
        mism     = '0;
        low_lane = '0;
        for (int i = LANES - 1; i >= 1; i--) begin
            if (mode) begin
                mism[i] = {ra[i], rb[i], rc[i], ro[i]} != {ra[0], rb[0], rc[0], ro[0]};
            end else begin
                mism[i] = dout_valid && (dline[i][DEPTH-1] != dline[0][DEPTH-1]);
            end
            if (mism[i]) begin
                low_lane = FL_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt         <= '0;
            leak        <= '0;
            first_cycle <= '0;
            first_lane  <= '0;
        end else begin
            if (cnt != '1) begin
                cnt <= cnt + 1'b1;
            end
            leak <= clear ? mism : (leak | mism);
            // A mismatch coinciding with clear re-arms and captures in the same edge.
            if ((clear || !leak_any) && (mism != '0)) begin
                first_cycle <= cnt;
                first_lane  <= low_lane;
            end else if (clear) begin
                first_cycle <= '0;
                first_lane  <= '0;
            end
        end
    end

`ifdef LEAK_COUNT_EN
    logic [CNT_W-1:0] lcnt [LANES];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LANES; i++) begin
                lcnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (clear) begin
                    lcnt[i] <= {{(CNT_W-1){1'b0}}, mism[i]};
                end else if (mism[i] && (lcnt[i] != '1)) begin
                    lcnt[i] <= lcnt[i] + 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lcnt
        assign leak_count[g*CNT_W +: CNT_W] = lcnt[g];
    end
`endif

endmodule

// File: tb/tb_dup_lane_leak_checker.sv
// tb/tb_dup_lane_leak_checker.sv - self-checking bench for dup_lane_leak_checker.
module tb_dup_lane_leak_checker;
    localparam int W     = 8;
    localparam int LANES = 4;
    localparam int DEPTH = 2;
    localparam int CNT_W = 16;
    localparam int FL_W  = 2;

    logic                   clk = 1'b0;
    logic                   reset_n = 1'b1;
    logic                   valid_in = 1'b0;
    logic                   mode = 1'b0;
    logic                   clear = 1'b0;
    logic [W-1:0]           x = '0;
    logic [W-1:0]           y = '0;
    logic [W-1:0]           z = '0;
    logic [LANES*W-1:0]     h = '0;
    logic [LANES*W-1:0]     dout;
    logic                   dout_valid;
    logic [LANES-1:0]       leak;
    logic                   leak_any;
    logic [CNT_W-1:0]       first_cycle;
    logic [FL_W-1:0]        first_lane;
`ifdef LEAK_COUNT_EN
    logic [LANES*CNT_W-1:0] leak_count;
`endif

    dup_lane_leak_checker #(.W(W), .LANES(LANES), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .valid_in    (valid_in),
        .x           (x),
        .y           (y),
        .z           (z),
        .h           (h),
        .mode        (mode),
        .clear       (clear),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .leak        (leak),
        .leak_any    (leak_any),
        .first_cycle (first_cycle),
        .first_lane  (first_lane)
`ifdef LEAK_COUNT_EN
        ,
        .leak_count  (leak_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [LANES*W-1:0]     dout;
        logic                   dv;
        logic [LANES-1:0]       leak;
        logic                   la;
        logic [CNT_W-1:0]       fc;
        logic [FL_W-1:0]        fl;
        logic [LANES*CNT_W-1:0] lc;
    } exp_t;

    typedef struct {
        logic        mode;
        logic [31:0] h;
        logic [7:0]  x, y, z;
        int          nv;
        int          idle;
        bit          rnd;
        logic [3:0]  el;
        logic [1:0]  efl;
        logic [15:0] efc;
    } vec_t;

    exp_t sbq[$];
    vec_t vt[5];

    logic [W-1:0]     ma [LANES];
    logic [W-1:0]     mb [LANES];
    logic [W-1:0]     mc [LANES];
    logic [W-1:0]     mo [LANES];
    logic [W-1:0]     mdl [LANES][DEPTH];
    logic [DEPTH:0]   mvs;
    logic [CNT_W-1:0] mcnt;
    logic [LANES-1:0] mleak;
    logic [CNT_W-1:0] mfc;
    logic [FL_W-1:0]  mfl;
`ifdef LEAK_COUNT_EN
    logic [CNT_W-1:0] mlc [LANES];
`endif

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < LANES; i++) begin
            ma[i] = '0; mb[i] = '0; mc[i] = '0; mo[i] = '0;
            for (int j = 0; j < DEPTH; j++) mdl[i][j] = '0;
`ifdef LEAK_COUNT_EN
            mlc[i] = '0;
`endif
        end
        mvs = '0; mcnt = '0; mleak = '0; mfc = '0; mfl = '0;
    endtask

    function automatic exp_t model_out();
        exp_t e;
        for (int i = 0; i < LANES; i++) e.dout[i*W +: W] = mdl[i][DEPTH-1];
        e.dv   = mvs[DEPTH];
        e.leak = mleak;
        e.la   = |mleak;
        e.fc   = mfc;
        e.fl   = mfl;
        e.lc   = '0;
`ifdef LEAK_COUNT_EN
        for (int i = 0; i < LANES; i++) e.lc[i*CNT_W +: CNT_W] = mlc[i];
`endif
        return e;
    endfunction

    task automatic model_step();
        logic [LANES-1:0] mm;
        logic [FL_W-1:0]  low;
        bit               found;
        logic [W-1:0]     hv;
        mm = '0; low = '0; found = 0;
        for (int i = 1; i < LANES; i++) begin
            if (mode)
                mm[i] = (ma[i] != ma[0]) || (mb[i] != mb[0]) || (mc[i] != mc[0]) || (mo[i] != mo[0]);
            else
                mm[i] = mvs[DEPTH] && (mdl[i][DEPTH-1] != mdl[0][DEPTH-1]);
            if (mm[i] && !found) begin
                low = FL_W'(i);
                found = 1;
            end
        end
        if ((clear || mleak == '0) && found) begin
            mfc = mcnt; mfl = low;
        end else if (clear) begin
            mfc = '0; mfl = '0;
        end
        mleak = clear ? mm : (mleak | mm);
`ifdef LEAK_COUNT_EN
        for (int i = 1; i < LANES; i++) begin
            if (clear) mlc[i] = {15'd0, mm[i]};
            else if (mm[i] && mlc[i] != 16'hffff) mlc[i] = mlc[i] + 16'd1;
        end
`endif
        for (int i = 0; i < LANES; i++) begin
            for (int j = DEPTH - 1; j >= 1; j--) mdl[i][j] = mdl[i][j-1];
            mdl[i][0] = mo[i];
            if (valid_in) begin
                logic [W-1:0] na, nb, nc, no;
                hv = h[i*W +: W];
                nb = x - y;
                if (hv != 0) begin
                    nc = x + y;
                    na = mb[i] - mc[i];
                end else begin
                    nc = mc[i];
                    na = mb[i] + z;
                end
                no = ma[i] + mb[i] + mc[i];
                ma[i] = na; mb[i] = nb; mc[i] = nc; mo[i] = no;
            end
        end
        mvs = {mvs[DEPTH-1:0], valid_in};
        if (mcnt != 16'hffff) mcnt = mcnt + 16'd1;
    endtask

    task automatic tick();
        exp_t e;
        model_step();
        sbq.push_back(model_out());
        @(posedge clk);
        #1;
        cyc++;
        e = sbq.pop_front();
        check("sb_dout",  64'(dout),        64'(e.dout));
        check("sb_dv",    64'(dout_valid),  64'(e.dv));
        check("sb_leak",  64'(leak),        64'(e.leak));
        check("sb_any",   64'(leak_any),    64'(e.la));
        check("sb_fcyc",  64'(first_cycle), 64'(e.fc));
        check("sb_flane", 64'(first_lane),  64'(e.fl));
`ifdef LEAK_COUNT_EN
        check("sb_lcnt",  64'(leak_count),  64'(e.lc));
`endif
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check("rst_dout",  64'(dout),        64'd0);
        check("rst_dv",    64'(dout_valid),  64'd0);
        check("rst_leak",  64'(leak),        64'd0);
        check("rst_any",   64'(leak_any),    64'd0);
        check("rst_fcyc",  64'(first_cycle), 64'd0);
        check("rst_flane", 64'(first_lane),  64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        valid_in = 1'b0; clear = 1'b0;
        model_reset();
        sbq.delete();
        cyc = 0;
    endtask

    initial begin
        int n;
        logic [CNT_W-1:0] efc;
        vt[0] = '{1'b0, 32'h00000000, 8'd0, 8'd0, 8'd0, 10, 3, 1'b1, 4'b0000, 2'd0, 16'd0};
        vt[1] = '{1'b1, 32'h01010001, 8'd5, 8'd3, 8'd0, 1,  3, 1'b0, 4'b0010, 2'd1, 16'd3};
        vt[2] = '{1'b0, 32'h01010001, 8'd5, 8'd3, 8'd0, 2,  4, 1'b0, 4'b0010, 2'd1, 16'd6};
        vt[3] = '{1'b1, 32'h00000707, 8'd5, 8'd3, 8'd0, 1,  2, 1'b0, 4'b1100, 2'd2, 16'd3};
        vt[4] = '{1'b1, 32'h01020304, 8'd9, 8'd4, 8'd6, 3,  2, 1'b0, 4'b0000, 2'd0, 16'd0};
        #2;

        for (int v = 0; v < 5; v++) begin
            do_reset();
            mode = vt[v].mode; h = vt[v].h;
            x = vt[v].x; y = vt[v].y; z = vt[v].z;
            tick();
            tick();
            for (int k = 0; k < vt[v].nv; k++) begin
                if (vt[v].rnd) begin
                    x = 8'($urandom_range(255));
                    y = 8'($urandom_range(255));
                    z = 8'($urandom_range(255));
                end
                valid_in = 1'b1;
                tick();
            end
            valid_in = 1'b0;
            for (int k = 0; k < vt[v].idle; k++) tick();
            check($sformatf("v%0d_leak", v),  64'(leak),        64'(vt[v].el));
            check($sformatf("v%0d_flane", v), 64'(first_lane),  64'(vt[v].efl));
            check($sformatf("v%0d_fcyc", v),  64'(first_cycle), 64'(vt[v].efc));
        end

        // clear while a state mismatch is ongoing, then a clear with nothing pending
        do_reset();
        mode = 1'b1; h = 32'h01010001; x = 8'd5; y = 8'd3; z = 8'd0;
        tick(); tick();
        valid_in = 1'b1; tick();
        valid_in = 1'b0; tick(); tick();
        efc = 16'(cyc);
        clear = 1'b1; tick();
        clear = 1'b0;
        check("clr_mm_leak",  64'(leak),        64'h2);
        check("clr_mm_fcyc",  64'(first_cycle), 64'(efc));
        check("clr_mm_flane", 64'(first_lane),  64'd1);
`ifdef LEAK_COUNT_EN
        check("clr_mm_lcnt1", 64'(leak_count[CNT_W +: CNT_W]), 64'd1);
`endif
        mode = 1'b0;
        clear = 1'b1; tick();
        clear = 1'b0;
        check("clr_leak",  64'(leak),        64'd0);
        check("clr_fcyc",  64'(first_cycle), 64'd0);
        check("clr_flane", 64'(first_lane),  64'd0);
        efc = 16'(cyc);
        mode = 1'b1; tick();
        check("mode_sw_leak", 64'(leak),        64'h2);
        check("mode_sw_fcyc", 64'(first_cycle), 64'(efc));

        // asynchronous reset with dout_valid high, then latency of the next valid
        do_reset();
        mode = 1'b0; h = 32'h00000001; x = 8'd7; y = 8'd2; z = 8'd1;
        valid_in = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        valid_in = 1'b0;
        check("pre_rst_dv", 64'(dout_valid), 64'd1);
        do_reset();
        valid_in = 1'b1; tick();
        valid_in = 1'b0;
        n = 99;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (dout_valid && n == 99) n = k;
        end
        check("dv_latency", 64'(n), 64'(DEPTH));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
